traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Parametrised 4-phase traffic-light sequencer with a per-second countdown for the 7-seg driver.
//  Sequence: NS green -> NS yellow -> EW green -> EW yellow -> NS green.
//  Each phase duration is set independently.
//  Also provides hold (freeze) and a night-flash mode.
//  Sits between the system clock and the seg/light output drivers.
//  Exports binary and BCD countdown, phase index and lamp vectors.
// PARAMETERS
//  CLK_DIV  50  clk cycles per countdown second; legal range >=2
//  T_NSG    30  NS green duration in seconds; legal range 1..99
//  T_NSY    3   NS yellow duration in seconds; legal range 1..99
//  T_EWG    15  EW green duration in seconds; legal range 1..99
//  T_EWY    3   EW yellow duration in seconds; legal range 1..99
// PORTS
//  clk       in   1  system clock; all state changes on rising edge
//  rst_n     in   1  asynchronous reset, active low
//  en        in   1  1 = run; 0 = freeze prescaler, countdown, phase and blink (outputs hold)
//  flash_req in   1  level; 1 = night-flash mode
//  phase     out  2  0 NSG, 1 NSY, 2 EWG, 3 EWY; holds last value while flashing
//  ns_light  out  3  NS lamps {R,Y,G}, one-hot except flash-off (000)
//  ew_light  out  3  EW lamps {R,Y,G}
//  cnt_bin   out  7  seconds remaining in phase, counts T-1 down to 0
//  cnt_tens  out  4  BCD tens digit of cnt_bin
//  cnt_ones  out  4  BCD ones digit of cnt_bin
//  sec_tick  out  1  one-cycle pulse at each second boundary
//  flashing  out  1  1 while in FLASH state
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   phase=0, cnt_bin=T_NSG-1, ns_light=001, ew_light=100.
//   sec_tick=0, flashing=0, prescaler=0, blink=1.
//  Prescaler:
//   div_cnt counts 0..CLK_DIV-1 and only advances when en=1.
//   sec_tick=1 for exactly the cycle where div_cnt==CLK_DIV-1 and en=1; div_cnt then wraps to 0.
//  Countdown (RUN state, on sec_tick):
//   cnt_bin>0: decrement.
//   cnt_bin==0: advance phase (3 wraps to 0) and load T_next-1 in the same cycle.
//   Each phase therefore lasts exactly T_P*CLK_DIV enabled cycles; no extra or missing second.
//  Lamps are decoded from phase and are registered or equivalent glitch-free:
//   NSG: ns=001, ew=100
//   NSY: ns=010, ew=100
//   EWG: ns=100, ew=001
//   EWY: ns=100, ew=010
//  BCD: cnt_tens=cnt_bin/10 and cnt_ones=cnt_bin%10.
//   Valid whenever cnt_bin changes, with zero extra latency versus cnt_bin.
//  FSM states: RUN, FLASH.
//   RUN->FLASH: flash_req=1 sampled on any edge; takes effect next cycle regardless of en or sec_tick.
//    flash_req wins over a simultaneous phase advance.
//   On FLASH entry: blink=1, cnt_bin=0, flashing=1.
//   In FLASH: ns_light=ew_light={0,blink,0}; blink toggles on each sec_tick.
//   FLASH->RUN: flash_req=0.
//    Next cycle: phase=0, cnt_bin=T_NSG-1, div_cnt=0, flashing=0, lamps per NSG.
//  en=0 mid-phase freezes all state; resuming continues from the exact div_cnt value.
//  Reset asserted mid-operation restores reset values immediately (asynchronously).
// TESTING
//  (CLK_DIV=4, T_NSG=3, T_NSY=2, T_EWG=2, T_EWY=1 unless noted)
//  1. Release reset, en=1.
//     -> sec_tick every 4th cycle.
//     -> cnt_bin 2,1,0 then phase 1 with cnt_bin=1.
//     -> Full cycle is 32 clk; phase returns to 0 with cnt_bin=2.
//  2. Drop en for 10 cycles at div_cnt=2.
//     -> All outputs frozen.
//     -> Next sec_tick arrives 2 enabled cycles after en rises.
//  3. Assert flash_req in the same cycle as the EWY->NSG advance.
//     -> FLASH next cycle, cnt_bin=0, lamps 010/010.
//     -> Lamps toggle to 000 at the next sec_tick.
//  4. Deassert flash_req.
//     -> Next cycle phase=0, cnt_bin=2, ns=001, ew=100.
//     -> First sec_tick 4 cycles later.
//  5. Defaults (CLK_DIV=50, T_NSG=30).
//     -> cnt_tens/ones read 2/9 after reset.
//     -> 1/0 when cnt_bin=10, 0/9 when cnt_bin=9.
//  6. Pulse rst_n low mid-EWG for 1 cycle.
//     -> Outputs return to reset values asynchronously.
//     -> Sequence restarts at NSG.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Four-phase traffic sequencer (NSG->NSY->EWG->EWY) with per-second countdown, hold and night-flash.
// Latency: lamps, phase and count update one clk after the deciding edge; BCD and sec_tick are combinational.
module traffic_phase_ctrl #(
    parameter int CLK_DIV = 50,
    parameter int T_NSG   = 30,
    parameter int T_NSY   = 3,
    parameter int T_EWG   = 15,
    parameter int T_EWY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       flash_req,
    output logic [1:0] phase,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] cnt_bin,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       sec_tick,
    output logic       flashing
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {S_RUN, S_FLASH} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [6:0]    cnt_nxt;
    logic [1:0]    phase_nxt;
    logic          blink, blink_nxt;
    logic          tick;
    logic [5:0]    lamp_nxt;

    function automatic logic [6:0] load_val(input logic [1:0] p);
        case (p)
            2'd0:    return 7'(T_NSG - 1);
            2'd1:    return 7'(T_NSY - 1);
            2'd2:    return 7'(T_EWG - 1);
            default: return 7'(T_EWY - 1);
        endcase
    endfunction

    // {ns, ew} lamp pair; in flash both heads show yellow gated by blink
    function automatic logic [5:0] lamps(input logic [1:0] p, input logic fl, input logic bl);
        if (fl)
            return {1'b0, bl, 1'b0, 1'b0, bl, 1'b0};
        case (p)
            2'd0:    return 6'b001_100;
            2'd1:    return 6'b010_100;
            2'd2:    return 6'b100_001;
            default: return 6'b100_010;
        endcase
    endfunction

    assign tick = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            div_cnt  <= '0;
            cnt_bin  <= load_val(2'd0);
            phase    <= 2'd0;
            blink    <= 1'b1;
            ns_light <= 3'b001;
            ew_light <= 3'b100;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            cnt_bin  <= cnt_nxt;
            phase    <= phase_nxt;
            blink    <= blink_nxt;
            ns_light <= lamp_nxt[5:3];
            ew_light <= lamp_nxt[2:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (flash_req)  state_nxt = S_FLASH;
            S_FLASH: if (!flash_req) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Datapath next values; flash transitions override en so mode changes never stall
    always_comb begin
        div_nxt   = div_cnt;
        cnt_nxt   = cnt_bin;
        phase_nxt = phase;
        blink_nxt = blink;
        if (en)
            div_nxt = tick ? '0 : div_cnt + 1'b1;
        if (state == S_RUN) begin
            if (flash_req) begin
                cnt_nxt   = 7'd0;
                blink_nxt = 1'b1;
            end else if (tick) begin
                if (cnt_bin == 7'd0) begin
                    phase_nxt = phase + 2'd1;
                    cnt_nxt   = load_val(phase + 2'd1);
                end else begin
                    cnt_nxt = cnt_bin - 7'd1;
                end
            end
        end else begin
            if (!flash_req) begin
                phase_nxt = 2'd0;
                cnt_nxt   = load_val(2'd0);
                div_nxt   = '0;
                blink_nxt = 1'b1;
            end else if (tick) begin
                blink_nxt = ~blink;
            end
        end
        lamp_nxt = lamps(phase_nxt, state_nxt == S_FLASH, blink_nxt);
    end

    always_comb begin
        sec_tick = tick;
        flashing = (state == S_FLASH);
        cnt_tens = 4'(cnt_bin / 7'd10);
        cnt_ones = 4'(cnt_bin % 7'd10);
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench: small-parameter instance for sequencing/hold/flash/reset, default instance for BCD.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, flash_req;
    logic [1:0] phase;
    logic [2:0] ns_light, ew_light;
    logic [6:0] cnt_bin;
    logic [3:0] cnt_tens, cnt_ones;
    logic       sec_tick, flashing;

    logic       rst_n_d, en_d, flash_req_d;
    logic [1:0] phase_d;
    logic [2:0] ns_light_d, ew_light_d;
    logic [6:0] cnt_bin_d;
    logic [3:0] cnt_tens_d, cnt_ones_d;
    logic       sec_tick_d, flashing_d;

    int tests = 0;
    int fails = 0;

    // Expected phase/count per elapsed second over one 8-second cycle, and lamps per phase
    int exp_ph[9]  = '{0, 0, 0, 1, 1, 2, 2, 3, 0};
    int exp_cnt[9] = '{2, 1, 0, 1, 0, 1, 0, 0, 2};
    int exp_ns[4]  = '{1, 2, 4, 4};
    int exp_ew[4]  = '{4, 4, 1, 2};

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .CLK_DIV(4), .T_NSG(3), .T_NSY(2), .T_EWG(2), .T_EWY(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flash_req(flash_req),
        .phase(phase), .ns_light(ns_light), .ew_light(ew_light),
        .cnt_bin(cnt_bin), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
        .sec_tick(sec_tick), .flashing(flashing)
    );

    traffic_phase_ctrl u_def (
        .clk(clk), .rst_n(rst_n_d), .en(en_d), .flash_req(flash_req_d),
        .phase(phase_d), .ns_light(ns_light_d), .ew_light(ew_light_d),
        .cnt_bin(cnt_bin_d), .cnt_tens(cnt_tens_d), .cnt_ones(cnt_ones_d),
        .sec_tick(sec_tick_d), .flashing(flashing_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs n enabled cycles from a fresh NSG start (div_cnt=0) and checks against the table
    task automatic run_seq(input string tag, input int n);
        int s;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            s = k / 4;
            check({tag, "_tick"},  32'(sec_tick), 32'((k % 4) == 3));
            check({tag, "_phase"}, 32'(phase),    32'(exp_ph[s]));
            check({tag, "_cnt"},   32'(cnt_bin),  32'(exp_cnt[s]));
            check({tag, "_ns"},    32'(ns_light), 32'(exp_ns[exp_ph[s]]));
            check({tag, "_ew"},    32'(ew_light), 32'(exp_ew[exp_ph[s]]));
            check({tag, "_ones"},  32'(cnt_ones), 32'(exp_cnt[s]));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; flash_req = 1'b0;
        rst_n_d = 1'b0; en_d = 1'b0; flash_req_d = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_phase", 32'(phase), 0);
        check("rst_cnt", 32'(cnt_bin), 2);
        check("rst_ns", 32'(ns_light), 1);
        check("rst_ew", 32'(ew_light), 4);
        check("rst_tick", 32'(sec_tick), 0);
        check("rst_flash", 32'(flashing), 0);
        check("def_rst_cnt", 32'(cnt_bin_d), 29);
        check("def_rst_tens", 32'(cnt_tens_d), 2);
        check("def_rst_ones", 32'(cnt_ones_d), 9);

        // 1: full 32-cycle sequence
        rst_n = 1'b1; en = 1'b1;
        run_seq("t1", 32);

        // 2: hold at div_cnt=2 for 10 cycles
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold_phase", 32'(phase), 0);
            check("t2_hold_cnt", 32'(cnt_bin), 2);
            check("t2_hold_tick", 32'(sec_tick), 0);
            check("t2_hold_ns", 32'(ns_light), 1);
        end
        en = 1'b1;
        @(negedge clk);
        check("t2_resume_tick", 32'(sec_tick), 1);
        check("t2_resume_cnt", 32'(cnt_bin), 2);
        @(negedge clk);
        check("t2_after_tick", 32'(sec_tick), 0);
        check("t2_after_cnt", 32'(cnt_bin), 1);

        // 3: flash_req coincides with EWY->NSG advance
        repeat (27) @(negedge clk);
        check("t3_pre_phase", 32'(phase), 3);
        check("t3_pre_cnt", 32'(cnt_bin), 0);
        check("t3_pre_tick", 32'(sec_tick), 1);
        flash_req = 1'b1;
        @(negedge clk);
        check("t3_flashing", 32'(flashing), 1);
        check("t3_cnt", 32'(cnt_bin), 0);
        check("t3_phase_hold", 32'(phase), 3);
        check("t3_ns_on", 32'(ns_light), 2);
        check("t3_ew_on", 32'(ew_light), 2);
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("t3_tick", 32'(sec_tick), 1);
        check("t3_ns_still_on", 32'(ns_light), 2);
        @(negedge clk);
        check("t3_ns_off", 32'(ns_light), 0);
        check("t3_ew_off", 32'(ew_light), 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("t3_ns_on_again", 32'(ns_light), 2);

        // 4: leave flash
        flash_req = 1'b0;
        @(negedge clk);
        check("t4_flashing", 32'(flashing), 0);
        check("t4_phase", 32'(phase), 0);
        check("t4_cnt", 32'(cnt_bin), 2);
        check("t4_ns", 32'(ns_light), 1);
        check("t4_ew", 32'(ew_light), 4);
        check("t4_tens", 32'(cnt_tens), 0);
        @(negedge clk);
        check("t4_tick_a", 32'(sec_tick), 0);
        @(negedge clk);
        check("t4_tick_b", 32'(sec_tick), 0);
        @(negedge clk);
        check("t4_tick_c", 32'(sec_tick), 1);
        @(negedge clk);
        check("t4_cnt_dec", 32'(cnt_bin), 1);

        // 6: async reset pulse mid-EWG
        repeat (16) @(negedge clk);
        check("t6_in_ewg", 32'(phase), 2);
        check("t6_in_ewg_ew", 32'(ew_light), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_phase", 32'(phase), 0);
        check("t6_async_cnt", 32'(cnt_bin), 2);
        check("t6_async_ns", 32'(ns_light), 1);
        check("t6_async_ew", 32'(ew_light), 4);
        check("t6_async_tick", 32'(sec_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("t6", 12);

        // 5: default parameters, BCD split
        rst_n_d = 1'b1; en_d = 1'b1;
        repeat (950) @(negedge clk);
        check("t5_cnt10", 32'(cnt_bin_d), 10);
        check("t5_tens10", 32'(cnt_tens_d), 1);
        check("t5_ones10", 32'(cnt_ones_d), 0);
        repeat (50) @(negedge clk);
        check("t5_cnt9", 32'(cnt_bin_d), 9);
        check("t5_tens9", 32'(cnt_tens_d), 0);
        check("t5_ones9", 32'(cnt_ones_d), 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
